// File: rtl/ram64_arbiter.sv
// Two-port round-robin arbiter sharing one 64x16 ram64 between two level-req / pulse-ack requesters.
// Each transaction is IDLE -> ACCESS (one RAM cycle) -> DONE (ack + read data), so grants are 3 cycles apart.
module ram64_arbiter #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              ack0,
    output logic [DATA_W-1:0] rdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata1,
    output logic              mem_load,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data_in,
    input  logic [DATA_W-1:0] mem_data_out,
    output logic              busy,
    output logic              grant
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t              state_q, state_d;
    logic                lat_we_q, lat_we_d;
    logic [ADDR_W-1:0]   lat_addr_q, lat_addr_d;
    logic [DATA_W-1:0]   lat_wdata_q, lat_wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                last_grant_q, last_grant_d;
    logic                grant_q, grant_d;
    logic                win_any;
    logic                winner;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            lat_we_q     <= 1'b0;
            lat_addr_q   <= '0;
            lat_wdata_q  <= '0;
            rdata_q      <= '0;
            last_grant_q <= 1'b1;
            grant_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            lat_we_q     <= lat_we_d;
            lat_addr_q   <= lat_addr_d;
            lat_wdata_q  <= lat_wdata_d;
            rdata_q      <= rdata_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
        end
    end

    // On a tie the port that did not win last time gets the slot.
    always_comb begin
        win_any = req0 | req1;
        if (req0 && req1) winner = ~last_grant_q;
        else              winner = req1;
    end

    always_comb begin
        state_d      = state_q;
        lat_we_d     = lat_we_q;
        lat_addr_d   = lat_addr_q;
        lat_wdata_d  = lat_wdata_q;
        rdata_d      = rdata_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        case (state_q)
            IDLE: begin
                if (win_any) begin
                    lat_we_d     = winner ? we1 : we0;
                    lat_addr_d   = winner ? addr1 : addr0;
                    lat_wdata_d  = winner ? wdata1 : wdata0;
                    grant_d      = winner;
                    last_grant_d = winner;
                    state_d      = ACCESS;
                end
            end
            ACCESS: begin
                rdata_d = mem_data_out;
                state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // rst_n gating keeps a reset cycle from writing the RAM or acking a requester.
    always_comb begin
        mem_load    = (state_q == ACCESS) & lat_we_q & rst_n;
        mem_address = lat_addr_q;
        mem_data_in = lat_wdata_q;
        busy        = (state_q == ACCESS) | (state_q == DONE);
        grant       = grant_q;
        ack0        = (state_q == DONE) & ~grant_q & rst_n;
        ack1        = (state_q == DONE) & grant_q & rst_n;
        rdata0      = ack0 ? rdata_q : '0;
        rdata1      = ack1 ? rdata_q : '0;
    end

endmodule

// File: tb/tb_ram64_arbiter.sv
// Scoreboard bench for ram64_arbiter: directed transactions push expected acks, a negedge monitor pops and compares.
// A behavioural 64x16 RAM with a side preload port stands in for ram64.
module tb_ram64_arbiter;

    typedef struct packed {
        logic        port;
        logic [15:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0, we0, req1, we1;
    logic [5:0]  addr0, addr1;
    logic [15:0] wdata0, wdata1;
    logic        ack0, ack1;
    logic [15:0] rdata0, rdata1;
    logic        mem_load;
    logic [5:0]  mem_address;
    logic [15:0] mem_data_in;
    logic [15:0] mem_data_out;
    logic        busy, grant;

    logic        pre_we;
    logic [5:0]  pre_addr;
    logic [15:0] pre_data;
    logic [15:0] mem [64];

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ram64_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0), .rdata0(rdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1), .rdata1(rdata1),
        .mem_load(mem_load), .mem_address(mem_address), .mem_data_in(mem_data_in),
        .mem_data_out(mem_data_out), .busy(busy), .grant(grant)
    );

    always @(posedge clk) begin
        if (mem_load)    mem[mem_address] <= mem_data_in;
        else if (pre_we) mem[pre_addr]    <= pre_data;
    end
    assign mem_data_out = mem[mem_address];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every ack must match the head of the scoreboard.
    always @(negedge clk) begin
        if (ack0 || ack1) begin
            check("ack_onehot", {31'd0, ack0 & ack1}, 32'd0);
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ack ack0=%b ack1=%b (cycle %0d)", ack0, ack1, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("ack_port", {31'd0, ack1}, {31'd0, e.port});
                check("grant_at_ack", {31'd0, grant}, {31'd0, e.port});
                check("ack_rdata", {16'd0, ack1 ? rdata1 : rdata0}, {16'd0, e.data});
                check("other_rdata_zero", {16'd0, ack1 ? rdata0 : rdata1}, 32'd0);
            end
        end
    end

    task automatic drive(input bit p, input bit we, input logic [5:0] a, input logic [15:0] d);
        if (p) begin req1 = 1'b1; we1 = we; addr1 = a; wdata1 = d; end
        else   begin req0 = 1'b1; we0 = we; addr0 = a; wdata0 = d; end
    endtask

    task automatic drop(input bit p);
        if (p) req1 = 1'b0;
        else   req0 = 1'b0;
    endtask

    task automatic push(input bit p, input logic [15:0] d);
        exp_t e;
        e.port = p;
        e.data = d;
        sb.push_back(e);
    endtask

    // Counts negedges before the ack of port p and the mem_load cycles seen on the way.
    task automatic wait_ack(input bit p, output int lat, output int loads, output int at_cyc);
        lat = 0;
        loads = 0;
        at_cyc = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (mem_load) loads++;
            if (p ? ack1 : ack0) begin
                at_cyc = cyc;
                return;
            end
            lat++;
        end
        checks++;
        errors++;
        $display("FAIL ack_timeout port=%0d actual=none expected=ack", p);
    endtask

    task automatic txn(input bit p, input bit we, input logic [5:0] a, input logic [15:0] d,
                       input logic [15:0] exp_rd);
        int lat, loads, c;
        @(posedge clk); #1;
        push(p, exp_rd);
        drive(p, we, a, d);
        wait_ack(p, lat, loads, c);
        check("latency", lat, 2);
        check("load_cycles", loads, {31'd0, we});
        @(posedge clk); #1;
        drop(p);
    endtask

    task automatic preload(input logic [5:0] a, input logic [15:0] d);
        @(posedge clk); #1;
        pre_we = 1'b1; pre_addr = a; pre_data = d;
        @(posedge clk); #1;
        pre_we = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        int lat, loads, c0, c1, n0, n1;
        bit got;
        rst_n = 1'b0;
        req0 = 0; we0 = 0; addr0 = '0; wdata0 = '0;
        req1 = 0; we1 = 0; addr1 = '0; wdata1 = '0;
        pre_we = 0; pre_addr = '0; pre_data = '0;

        // Clear the RAM while the DUT is held in reset.
        for (int a = 0; a < 64; a++) begin
            @(posedge clk); #1;
            pre_we = 1'b1; pre_addr = a[5:0]; pre_data = '0;
        end
        @(posedge clk); #1;
        pre_we = 1'b0;
        rst_n = 1'b1;

        @(negedge clk);
        check("rst_outputs", {24'd0, ack0, ack1, busy, mem_load, grant, 3'd0}, 32'd0);
        check("rst_rdata", {rdata0, rdata1}, 32'd0);
        check("rst_mem_addr", {10'd0, mem_address, mem_data_in}, 32'd0);

        // 1: port 0 write then read back.
        txn(0, 1, 6'h14, 16'hBEEF, 16'h0000);
        txn(0, 0, 6'h14, 16'h0000, 16'hBEEF);

        // 2: tie after reset, port 0 first, port 1 three cycles later.
        do_reset();
        preload(6'h00, 16'h1111);
        preload(6'h3F, 16'h2222);
        @(posedge clk); #1;
        push(0, 16'h1111);
        push(1, 16'h2222);
        drive(0, 0, 6'h00, 16'h0);
        drive(1, 0, 6'h3F, 16'h0);
        wait_ack(0, lat, loads, c0);
        check("tie_lat0", lat, 2);
        @(posedge clk); #1;
        drop(0);
        wait_ack(1, lat, loads, c1);
        check("tie_lat1", lat, 2);
        check("tie_spacing", c1 - c0, 3);
        @(posedge clk); #1;
        drop(1);

        // 3: both held for 8 transactions must alternate 0,1,0,1...
        @(posedge clk); #1;
        for (int i = 0; i < 8; i++) push(i[0], i[0] ? 16'h2222 : 16'h1111);
        drive(0, 0, 6'h00, 16'h0);
        drive(1, 0, 6'h3F, 16'h0);
        n0 = 0;
        n1 = 0;
        for (int i = 0; i < 8; i++) begin
            got = 1'b0;
            for (int k = 0; k < 10 && !got; k++) begin
                @(negedge clk);
                if (ack0 || ack1) got = 1'b1;
            end
            if (!got) begin
                checks++;
                errors++;
                $display("FAIL fair_timeout actual=none expected=ack index=%0d", i);
            end else begin
                check("fair_seq", {31'd0, ack1}, {31'd0, i[0]});
                if (ack1) n1++;
                else      n0++;
            end
        end
        @(posedge clk); #1;
        drop(0);
        drop(1);
        check("fair_cnt0", n0, 4);
        check("fair_cnt1", n1, 4);

        // 4: port 1 writes, port 0 reads it back.
        txn(1, 1, 6'h2A, 16'h1234, 16'h0000);
        txn(0, 0, 6'h2A, 16'h0000, 16'h1234);

        // 5: reset during ACCESS cancels the write and the ack.
        @(posedge clk); #1;
        drive(0, 1, 6'h05, 16'hDEAD);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_access_load", {31'd0, mem_load}, 32'd0);
        check("rst_access_ack", {30'd0, ack0, ack1}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        drop(0);
        repeat (4) begin
            @(negedge clk);
            check("post_rst_quiet", {29'd0, busy, ack0, ack1}, 32'd0);
        end
        txn(0, 0, 6'h05, 16'h0000, 16'h0000);

        // 6: idle with no requests.
        repeat (10) begin
            @(negedge clk);
            check("idle_quiet", {28'd0, busy, mem_load, ack0, ack1}, 32'd0);
        end

        repeat (3) @(negedge clk);
        check("sb_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/ram64_arbiter.md
Name: ram64_arbiter

Overview:
- Two-port round-robin arbiter that shares one ram64 instance (64 x 16-bit) between two requesters, e.g. CPU data port (port 0) and screen/IO refresh engine (port 1).
- Each requester uses a level req / single-cycle ack handshake. The arbiter latches the winner's command, drives the RAM for exactly one cycle, and returns read data with ack.
- Sits between requesters and the ram64 load/address/data_in/data_out pins. ram64 reads are combinational and writes commit on the clock edge.

Parameters:
- ADDR_W, 6, RAM address width; must match the ram64 address port.
- DATA_W, 16, data width.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  synchronous active-low reset.
- req0  input  1  port 0 request, level; held until ack0.
- we0  input  1  port 0 write enable (1 = write, 0 = read).
- addr0  input  ADDR_W  port 0 address.
- wdata0  input  DATA_W  port 0 write data.
- ack0  output  1  one-cycle completion pulse, port 0.
- rdata0  output  DATA_W  port 0 read data, valid while ack0 = 1.
- req1, we1, addr1, wdata1, ack1, rdata1: same as port 0, for port 1.
- mem_load  output  1  to ram64 load.
- mem_address  output  ADDR_W  to ram64 address.
- mem_data_in  output  DATA_W  to ram64 data_in.
- mem_data_out  input  DATA_W  from ram64 data_out (combinational read).
- busy  output  1  high in ACCESS and DONE.
- grant  output  1  id of the port owning the current or last transaction.

Behaviour:
- FSM with states IDLE, ACCESS, DONE. Reset state is IDLE.
- IDLE:
  - If no req is high, stay in IDLE.
  - If exactly one req is high, that port wins.
  - If both are high, the port != last_grant wins.
  - On winning: latch we, addr and wdata of the winner into lat_we/lat_addr/lat_wdata, set grant = winner, set last_grant = winner, go to ACCESS.
- ACCESS (exactly 1 cycle):
  - mem_address = lat_addr; mem_data_in = lat_wdata.
  - mem_load = lat_we & rst_n. It is gated combinationally so no write occurs in a reset cycle.
  - At the clock edge, capture mem_data_out into rdata_q (also done for writes, returning post-write-independent old data is not required), then go to DONE.
- DONE (exactly 1 cycle):
  - ack[grant] = 1; rdata[grant] = rdata_q; the other port's ack = 0. Next state is IDLE.
- Latency: req seen in IDLE at cycle N → RAM accessed in N+1 → ack in N+2. Minimum spacing between transactions is 3 cycles.
- Read data semantics: a read returns the RAM contents as of the ACCESS cycle, including any write committed by a previous transaction.
- Handshake rules:
  - A requester must keep req, we, addr and wdata stable from req rise until the ack cycle. They are sampled only in IDLE.
  - A requester drops req on the edge that ends its ack cycle.
  - A req still high in the IDLE cycle after ack is a new request.
- Outputs outside ACCESS: mem_load = 0. mem_address and mem_data_in hold their latched values, which is harmless because load is 0.
- Reset values: state = IDLE; lat_we/lat_addr/lat_wdata = 0; rdata_q = 0; last_grant = 1 (so port 0 wins the first tie); grant = 0; ack0 = ack1 = 0; rdata0 = rdata1 = 0; busy = 0; mem_load = 0.
- Reset mid-operation:
  - Reset asserted in ACCESS: no write occurs, the FSM returns to IDLE, and no ack is issued. The transaction is lost and the requester must re-request.
  - Reset asserted in DONE: ack is suppressed that cycle.
- Simultaneous req0/req1 held continuously: grants strictly alternate 0, 1, 0, 1. Neither port waits more than one transaction.
- rdata of a non-granted port is 0 (outputs muxed by ack, not by grant).
- No X propagation: all outputs are defined from the first post-reset cycle.

Test Plan:
1. Single write/read, port 0: write addr 6'h14 data 16'hBEEF → mem_load=1 for exactly 1 cycle, ack0 at N+2. Then read addr 6'h14 → ack0 with rdata0=16'hBEEF, and ack1 stays 0.
2. Tie after reset: req0 (read 6'h00) and req1 (read 6'h3F) rise together, memory preloaded with 16'h1111 at 6'h00 and 16'h2222 at 6'h3F → ack0 first with 16'h1111, then ack1 3 cycles later with 16'h2222.
3. Fairness: both req held high for 8 transactions → grant sequence 0,1,0,1,0,1,0,1 and ack count 4/4.
4. Write then cross-port read: port 1 writes 6'h2A = 16'h1234, then port 0 reads 6'h2A → rdata0 = 16'h1234.
5. Reset in ACCESS: port 0 writes 6'h05 = 16'hDEAD, rst_n=0 during the ACCESS cycle → mem_load stays 0, no ack0, and a later read of 6'h05 returns the prior value (0 after reset).
6. Idle behaviour: no req for 10 cycles → busy=0, mem_load=0, ack0=ack1=0 throughout.
